// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Keeps at most one imem request in flight and holds a one-entry skid buffer for words that return while stalled.
module fetch_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_stall,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic            o_if_valid,
  output logic [XLEN-1:0] o_if_pc,
  output logic [XLEN-1:0] o_if_instr,
  output logic [6:0]      o_opcode
);

  localparam int unsigned OPC_W = 7;

  typedef enum logic [2:0] {
    S_RESET,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_KILL
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;
  logic            imem_req_c;
  logic [XLEN-1:0] redirect_pc_aligned;

  // Redirect targets are forced to word alignment.
  assign redirect_pc_aligned = i_redirect_pc & ~XLEN'(3);

  // State and pipeline registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= S_RESET;
      pc_q         <= RESET_PC;
      if_valid_q   <= 1'b0;
      if_pc_q      <= '0;
      if_instr_q   <= NOP_INSTR;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  // Next-state, IF/ID update and request generation.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    if_valid_d   = if_valid_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    imem_req_c   = 1'b0;

    case (state_q)
      S_RESET: begin
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (!i_stall) begin
          imem_req_c = 1'b1;
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSTR;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_imem_rvalid && !i_stall) begin
          if_valid_d = 1'b1;
          if_pc_d    = pc_q;
          if_instr_d = i_imem_rdata;
          pc_d       = pc_q + XLEN'(4);
          state_d    = S_ISSUE;
        end else if (i_imem_rvalid) begin
          skid_pc_d    = pc_q;
          skid_instr_d = i_imem_rdata;
          pc_d         = pc_q + XLEN'(4);
          state_d      = S_HOLD;
        end else if (!i_stall) begin
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSTR;
        end
      end
      S_HOLD: begin
        if (!i_stall) begin
          if_valid_d = 1'b1;
          if_pc_d    = skid_pc_q;
          if_instr_d = skid_instr_q;
          state_d    = S_ISSUE;
        end
      end
      S_KILL: begin
        if (i_imem_rvalid) begin
          state_d = S_ISSUE;
        end
      end
      default: begin
        state_d = S_RESET;
      end
    endcase

    // Redirect flushes IF/ID and the skid buffer, even while stalled.
    if (i_redirect && (state_q != S_RESET)) begin
      pc_d       = redirect_pc_aligned;
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR;
      case (state_q)
        S_ISSUE: state_d = i_stall ? S_ISSUE : S_KILL;
        S_WAIT:  state_d = i_imem_rvalid ? S_ISSUE : S_KILL;
        S_HOLD:  state_d = S_ISSUE;
        // A response arriving with the redirect retires the kill, so the FSM never waits on a word that is not coming.
        S_KILL:  state_d = i_imem_rvalid ? S_ISSUE : S_KILL;
        default: state_d = state_q;
      endcase
    end
  end

  assign o_imem_req  = imem_req_c;
  assign o_imem_addr = pc_q;
  assign o_if_valid  = if_valid_q;
  assign o_if_pc     = if_pc_q;
  assign o_if_instr  = if_instr_q;
  assign o_opcode    = if_instr_q[OPC_W-1:0];

endmodule
